// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Encodes RV64I instruction descriptions (R-type, ld, sd, beq,
//                addi) into 32-bit words and queues them, with a byte address
//                per word, in a 2-entry output FIFO for an instruction-memory
//                writer. Illegal requests are consumed, dropped and flagged
//                with a one-cycle err pulse.
//                Optional build macro: INSTR_ENCODER_RANGE_CHECK_EN -- also
//                rejects immediates that do not fit the target format.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    // Instruction classes selected by op_sel
    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_SD   = 3'd2;
    localparam logic [2:0] OP_BEQ  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;

    // FIFO occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [31:0]       w_instr;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       r_head_instr;
    logic [ADDR_W-1:0] r_head_addr;
    logic [31:0]       r_tail_instr;
    logic [ADDR_W-1:0] r_tail_addr;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic              r_err;

    // Encode the request into a 32-bit word and decide whether it is legal
    always_comb begin
        w_instr = '0;
        w_legal = 1'b1;
        case (op_sel)
            OP_R:    w_instr = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
            OP_LD:   w_instr = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
            OP_SD:   w_instr = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
            OP_BEQ:  w_instr = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                                imm[4:1], imm[11], 7'b1100011};
            OP_ADDI: w_instr = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            default: w_legal = 1'b0;
        endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        // 12-bit formats need imm[12] to be a pure sign extension of imm[11];
        // branch targets must be halfword aligned.
        if ((op_sel == OP_LD || op_sel == OP_SD || op_sel == OP_ADDI) &&
            (imm[12] != imm[11])) begin
            w_legal = 1'b0;
        end
        if ((op_sel == OP_BEQ) && imm[0]) begin
            w_legal = 1'b0;
        end
`endif
    end

    // Handshake qualifiers: illegal requests are accepted but never pushed
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = out_valid && out_ready;

    // FIFO occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO occupancy next-state; push and pop together leave the count alone
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = ST_FULL;
                else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
            end
            ST_FULL:  if (w_pop && !w_push) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // FIFO handshake outputs; a full FIFO still accepts when the head leaves
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        case (r_state)
            ST_EMPTY: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            ST_ONE: begin
                out_valid = 1'b1;
                in_ready  = 1'b1;
            end
            ST_FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    // FIFO storage: head feeds the outputs directly, tail holds the second word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_instr <= '0;
            r_head_addr  <= '0;
            r_tail_instr <= '0;
            r_tail_addr  <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head_instr <= w_instr;
                        r_head_addr  <= r_addr_cnt;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_instr <= w_instr;
                        r_head_addr  <= r_addr_cnt;
                    end else if (w_push) begin
                        r_tail_instr <= w_instr;
                        r_tail_addr  <= r_addr_cnt;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_head_instr <= r_tail_instr;
                        r_head_addr  <= r_tail_addr;
                        if (w_push) begin
                            r_tail_instr <= w_instr;
                            r_tail_addr  <= r_addr_cnt;
                        end
                    end
                end
                default: begin
                    r_head_instr <= r_head_instr;
                end
            endcase
        end
    end

    // Byte-address counter advances one word per legal push, wrapping freely
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_cnt <= '0;
        end else if (w_push) begin
            r_addr_cnt <= r_addr_cnt + ADDR_W'(4);
        end
    end

    // One-cycle error pulse for a consumed illegal request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
        end
    end

    assign out_instr = r_head_instr;
    assign out_addr  = r_head_addr;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Directed self-checking bench for instr_encoder (ADDR_W = 4
//                so that address wrap is reached within a short sequence).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op_sel;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [12:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err;

    int n_cmp = 0;
    int n_err = 0;
    int base;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sel    (op_sel),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [12:0] im);
        in_valid = 1'b1;
        op_sel   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
        imm      = im;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        op_sel   = 3'd0;
        rd       = 5'd0;
        rs1      = 5'd0;
        rs2      = 5'd0;
        funct3   = 3'd0;
        funct7   = 7'd0;
        imm      = 13'd0;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] ins, input int adr);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, ins);
        chk({tag, "_addr"}, 32'(out_addr), 32'(adr));
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        idle();
        tick();
        tick();
        // Reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr",  32'(out_addr), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // addi x1,x0,5
        req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5);
        tick();
        idle();
        chk_word("addi", 32'h00500093, 0);
        tick();
        chk("addi_drain", {31'd0, out_valid}, 32'd0);

        // Back-to-back ld / sd / add with streaming output (counter at 4)
        req(3'd1, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 13'd8);
        tick();
        chk_word("ld", 32'h0080B103, 4);
        req(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd16);
        tick();
        chk_word("sd", 32'h0020B823, 8);
        req(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'd0);
        tick();
        chk_word("add", 32'h002081B3, 12);
        // Fifth push wraps the 4-bit address to 0
        req(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FFC);
        tick();
        idle();
        chk_word("beq_wrap", 32'hFE208EE3, 0);
        tick();
        chk("b2b_drain", {31'd0, out_valid}, 32'd0);

        // Illegal op_sel: dropped, err pulse, address unchanged (counter at 4)
        req(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'd0);
        tick();
        idle();
        chk("ill_valid", {31'd0, out_valid}, 32'd0);
        chk("ill_err",   {31'd0, err}, 32'd1);
        req(3'd4, 5'd5, 5'd5, 5'd0, 3'd0, 7'd0, 13'h1FFF);
        tick();
        idle();
        chk("ill_err_clr", {31'd0, err}, 32'd0);
        chk_word("addi_neg", 32'hFFF28293, 4);
        tick();

        // Backpressure: two stored, third stalled until the first pop
        out_ready = 1'b0;
        req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd1);
        tick();
        chk_word("bp_a", 32'h00100093, 8);
        chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
        req(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd2);
        tick();
        chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        req(3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 13'd3);
        tick();
        chk("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
        chk_word("bp_hold", 32'h00100093, 8);
        out_ready = 1'b1;
        #1;
        chk("bp_pass_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        chk_word("bp_b", 32'h00200113, 12);
        tick();
        chk_word("bp_c", 32'h00300193, 0);
        tick();
        chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // Immediate at the edge of the 12-bit range (counter at 4)
        req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0800);
        tick();
        idle();
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        chk("rng_valid", {31'd0, out_valid}, 32'd0);
        chk("rng_err",   {31'd0, err}, 32'd1);
        base = 4;
`else
        chk_word("rng_addi", 32'h80000093, 4);
        chk("rng_err", {31'd0, err}, 32'd0);
        base = 8;
`endif
        tick();

        // sub, negative-offset sd, ld with junk rs2 (ignored)
        req(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 13'd0);
        tick();
        chk_word("sub", 32'h402081B3, base);
        req(3'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
        tick();
        chk_word("sd_neg", 32'hFE20BC23, (base + 4) % 16);
        req(3'd1, 5'd2, 5'd1, 5'd31, 3'd7, 7'h7F, 13'd8);
        tick();
        idle();
        chk_word("ld_junk", 32'h0080B103, (base + 8) % 16);
        tick();

        // Reset with FIFO full: contents discarded immediately
        out_ready = 1'b0;
        req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd1);
        tick();
        req(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'd2);
        tick();
        idle();
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_addr",  32'(out_addr), 32'd0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5);
        tick();
        idle();
        chk_word("post_rst", 32'h00500093, 0);
        tick();
        chk("post_rst_drain", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 10, width of the instruction-memory byte-address counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 in_valid  input  1  request carries a valid instruction description.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 op_sel  input  3  0=R-type, 1=ld, 2=sd, 3=beq, 4=addi; 5-7 illegal.
REQ-007 rd, rs1, rs2  input  5 each  register fields.
REQ-008 funct3  input  3  R-type only; funct7  input  7  R-type only.
REQ-009 imm  input  13  signed immediate; bits [11:0] for I/S, bits [12:0] for B.
REQ-010 out_valid  output  1  out_instr/out_addr hold an encoded word.
REQ-011 out_ready  input  1  downstream (instruction-memory writer) accepts the word.
REQ-012 out_instr  output  32  encoded RV64I instruction.
REQ-013 out_addr  output  ADDR_W  byte address for out_instr.
REQ-014 err  output  1  one-cycle pulse on a dropped illegal request.

Function
REQ-015 Request accepted when in_valid && in_ready; word transferred when out_valid && out_ready.
REQ-016 Encoding: R = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
REQ-017 ld = {imm[11:0], rs1, 3'b011, rd, 7'b0000011}; addi = {imm[11:0], rs1, 3'b000, rd, 7'b0010011}.
REQ-018 sd = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011}.
REQ-019 beq = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}; imm[0] ignored.
REQ-020 Unused fields for a class (e.g. rs2 on ld) are ignored, not encoded.
REQ-021 Encoded words pass through a 2-entry FIFO; out_instr/out_addr driven from FIFO head, registered.
REQ-022 Latency: accepted legal request appears on out_valid the next cycle when FIFO empty.
REQ-023 in_ready = 1 when FIFO count < 2, or count == 2 with a transfer this cycle (pass-through on full with simultaneous pop).
REQ-024 Simultaneous push and pop: count unchanged, order preserved.
REQ-025 Address counter assigns out_addr at push time; starts at 0, increments by 4 per legal push, wraps modulo 2^ADDR_W.
REQ-026 Illegal op_sel: request consumed (in_ready rules unchanged), nothing pushed, counter unchanged, err = 1 the following cycle for one cycle.
REQ-027 out_instr/out_addr stable while out_valid && !out_ready.
REQ-028 FIFO states: EMPTY(0), ONE(1), FULL(2); push from EMPTY->ONE, ONE->FULL; pop reverses; no overflow or underflow under any input.

Reset
REQ-029 On reset assertion, immediately: out_valid=0, err=0, FIFO count=0, address counter=0, out_instr=0, out_addr=0.
REQ-030 in_ready = 1 once reset deasserts; reset mid-transfer discards FIFO contents without emitting them.

Configuration
REQ-031 Macro INSTR_ENCODER_RANGE_CHECK_EN: when defined, a request is also illegal (REQ-026 behaviour) if imm[12] != imm[11] for ld/sd/addi, or imm[0] = 1 for beq.
REQ-032 Without INSTR_ENCODER_RANGE_CHECK_EN, imm truncated per REQ-017..019 with no check; err only for op_sel 5-7.

Verification
REQ-033 addi x1,x0,5 (op_sel=4, rd=1, rs1=0, imm=5) -> next cycle out_instr=0x00500093, out_addr=0.
REQ-034 Back-to-back ld x2,8(x1); sd x2,16(x1); add x3,x1,x2 (funct3=0, funct7=0), out_ready=1 -> 0x0080B103@0, 0x0020B823@4, 0x002081B3@8.
REQ-035 beq x1,x2,-4 (imm=13'h1FFC) -> 0xFE208EE3.
REQ-036 out_ready=0, three requests -> first two stored, in_ready=0 on third; raise out_ready -> words out in order, third accepted same cycle as first pop.
REQ-037 op_sel=6 -> no out_valid, err pulse 1 cycle, next legal word gets unchanged address; with RANGE_CHECK_EN, addi imm=13'h0800 -> err.
REQ-038 ADDR_W=4, five pushes from 0 -> addresses 0,4,8,12,0; reset asserted with FIFO FULL -> out_valid=0 immediately, next word at address 0.
